// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_pkg
// Description : Shared definitions for the div_iter iterative divider.
//               - state_e: 2-bit encoded FSM states (IDLE, DZERO, RUN, DONE)
//               - rem_lsb/quot_msb: field-index helpers for the packed
//                 {remainder, quotient} result bus
// Revision    : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DZERO = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Remainder occupies result[2W-1:W].
  function automatic int rem_lsb(input int width);
    return width;
  endfunction

  // Quotient occupies result[W-1:0].
  function automatic int quot_msb(input int width);
    return width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_clz.sv
`default_nettype none
// ============================================================================
// Module      : clz_count
// Description : Combinational leading-zero counter. Returns WIDTH for an
//               all-zero input. Only compiled when DIV_ITER_EARLY_OUT_EN is
//               defined, since it is used solely by the early-out path.
// Ports       : data_i  [WIDTH-1:0]  value to scan
//               count_o [CNT_W-1:0]  number of leading zeros
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef DIV_ITER_EARLY_OUT_EN
module clz_count #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  logic found;

  always_comb begin
    count_o = '0;
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (data_i[i]) begin
          found = 1'b1;
        end else begin
          count_o = count_o + CNT_W'(1);
        end
      end
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Parametrised radix-2 restoring iterative divider with
//               signed/unsigned support, annul (flush), divide-by-zero flag.
//               Optional leading-zero early-out under DIV_ITER_EARLY_OUT_EN.
// Ports       : clk, rst (sync, active-high)
//               start_i, annul_i, signed_i, opdata1_i (dividend),
//               opdata2_i (divisor)
//               result_o {rem, quot}, ready_o (DONE), busy_o (DZERO/RUN),
//               div_zero_o (DONE with zero divisor)
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int REM_LSB  = rem_lsb(WIDTH);
  localparam int QUOT_MSB = quot_msb(WIDTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]     div_q, div_d;   // |divisor|
  logic                 s1_q, s1_d;     // dividend negative (signed only)
  logic                 s2_q, s2_d;     // divisor negative (signed only)
  logic                 dz_q, dz_d;
  logic [2*WIDTH-1:0]   res_q, res_d;

  // Operand magnitudes captured at start
  logic                 neg1, neg2;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH-1:0]     dvd_init;
  logic [CNT_W-1:0]     n_init;

  assign neg1 = signed_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_i & opdata2_i[WIDTH-1];
  assign abs1 = neg1 ? -opdata1_i : opdata1_i;
  assign abs2 = neg2 ? -opdata2_i : opdata2_i;

`ifdef DIV_ITER_EARLY_OUT_EN
  logic [CNT_W-1:0] clz;
  logic [CNT_W-1:0] sig_bits;

  clz_count #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_clz (
    .data_i  (abs1),
    .count_o (clz)
  );

  // Skip the leading zero bits: they would only produce zero quotient bits.
  assign sig_bits = CNT_W'(WIDTH) - clz;
  assign n_init   = (sig_bits == '0) ? CNT_W'(1) : sig_bits;
  assign dvd_init = abs1 << clz;
`else
  assign n_init   = CNT_W'(WIDTH);
  assign dvd_init = abs1;
`endif

  // One restoring step. rem_q < div_q holds between steps, so the shifted
  // remainder is below 2*div_q and the (WIDTH+1)-bit trial result's MSB is
  // exactly the borrow: clear means trial >= 0.
  logic [WIDTH:0]   rem_sh, trial;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;

  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, div_q};
  assign ge       = ~trial[WIDTH];
  assign rem_step = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ge};

  // Sign correction applied on the final step, as the result enters DONE.
  assign quo_fix  = (s1_q ^ s2_q) ? -quo_step : quo_step;
  assign rem_fix  = s1_q ? -rem_step : rem_step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dz_d    = dz_q;
    res_d   = res_q;

    if (annul_i) begin
      state_d = IDLE;
      dz_d    = 1'b0;
      res_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            s1_d    = neg1;
            s2_d    = neg2;
            div_d   = abs2;
            rem_d   = '0;
            quo_d   = dvd_init;
            cnt_d   = n_init;
            res_d   = '0;
            dz_d    = (opdata2_i == '0);
            state_d = (opdata2_i == '0) ? DZERO : RUN;
          end
        end
        DZERO: begin
          res_d   = '0;
          state_d = DONE;
        end
        RUN: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d[2*WIDTH-1:REM_LSB] = rem_fix;
            res_d[QUOT_MSB:0]        = quo_fix;
            state_d                  = DONE;
          end
        end
        DONE: begin
          if (!start_i) begin
            dz_d    = 1'b0;
            res_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
    end
  end

  assign result_o   = res_q;
  assign ready_o    = (state_q == DONE);
  assign busy_o     = (state_q == DZERO) || (state_q == RUN);
  assign div_zero_o = (state_q == DONE) && dz_q;

endmodule
`default_nettype wire
